// File: rtl/rpn_stack_alu.sv
// RPN operand stack with an ALU on the top two entries. One command per valid/ready
// handshake. Multiply is a WIDTH-step shift-add; every other command retires in one cycle.
module rpn_stack_alu #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             done,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             err_under,
  output logic             err_over,
  output logic             err_arith
);

  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_DUP   = 3'b100;
  localparam logic [2:0] OP_SWAP  = 3'b101;
  localparam logic [2:0] OP_DROP  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;
  localparam int         SW       = $clog2(WIDTH + 1);

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     stack_reg [DEPTH];
  logic [WIDTH-1:0]     stack_next [DEPTH];
  logic [CW-1:0]        count_reg, count_next;
  logic                 done_reg, done_next;
  logic                 under_reg, under_next;
  logic                 over_reg, over_next;
  logic                 arith_reg, arith_next;
  logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]     mplier_reg, mplier_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [SW-1:0]        step_reg, step_next;

  logic [WIDTH:0]       sum_ext, diff_ext;
  logic [2*WIDTH-1:0]   partial;
  logic                 lt_two, is_empty, is_full;

  assign sum_ext  = {1'b0, stack_reg[1]} + {1'b0, stack_reg[0]};
  assign diff_ext = {1'b0, stack_reg[1]} - {1'b0, stack_reg[0]};
  assign partial  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign lt_two   = count_reg < CW'(2);
  assign is_empty = count_reg == '0;
  assign is_full  = count_reg == CW'(DEPTH);

  // Entries at or beyond count are always kept zero, so top/second need no masking.
  always_comb begin
    state_next  = state_reg;
    stack_next  = stack_reg;
    count_next  = count_reg;
    done_next   = 1'b0;
    under_next  = under_reg;
    over_next   = over_reg;
    arith_next  = arith_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    step_next   = step_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          done_next = 1'b1;
          case (op)
            OP_PUSH, OP_DUP: begin
              if (op == OP_DUP && is_empty) begin
                under_next = 1'b1;
              end else if (is_full) begin
                over_next = 1'b1;
              end else begin
                for (int i = 1; i < DEPTH; i++) stack_next[i] = stack_reg[i-1];
                stack_next[0] = (op == OP_PUSH) ? operand : stack_reg[0];
                count_next    = count_reg + CW'(1);
              end
            end
            OP_ADD, OP_SUB: begin
              if (lt_two) begin
                under_next = 1'b1;
              end else begin
                for (int i = 1; i < DEPTH - 1; i++) stack_next[i] = stack_reg[i+1];
                stack_next[DEPTH-1] = '0;
                stack_next[0] = (op == OP_ADD) ? sum_ext[WIDTH-1:0] : diff_ext[WIDTH-1:0];
                arith_next    = arith_reg | ((op == OP_ADD) ? sum_ext[WIDTH] : diff_ext[WIDTH]);
                count_next    = count_reg - CW'(1);
              end
            end
            OP_MUL: begin
              if (lt_two) begin
                under_next = 1'b1;
              end else begin
                done_next   = 1'b0;
                state_next  = ST_MUL;
                mcand_next  = {{WIDTH{1'b0}}, stack_reg[1]};
                mplier_next = stack_reg[0];
                acc_next    = '0;
                step_next   = '0;
              end
            end
            OP_SWAP: begin
              if (lt_two) begin
                under_next = 1'b1;
              end else begin
                stack_next[0] = stack_reg[1];
                stack_next[1] = stack_reg[0];
              end
            end
            OP_DROP: begin
              if (is_empty) begin
                under_next = 1'b1;
              end else begin
                for (int i = 0; i < DEPTH - 1; i++) stack_next[i] = stack_reg[i+1];
                stack_next[DEPTH-1] = '0;
                count_next = count_reg - CW'(1);
              end
            end
            default: begin
              for (int i = 0; i < DEPTH; i++) stack_next[i] = '0;
              count_next = '0;
              under_next = 1'b0;
              over_next  = 1'b0;
              arith_next = 1'b0;
            end
          endcase
        end
      end
      ST_MUL: begin
        acc_next    = partial;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        step_next   = step_reg + SW'(1);
        // Last shift-add step: commit the product and pop one entry.
        if (step_reg == SW'(WIDTH - 1)) begin
          for (int i = 1; i < DEPTH - 1; i++) stack_next[i] = stack_reg[i+1];
          stack_next[DEPTH-1] = '0;
          stack_next[0] = partial[WIDTH-1:0];
          arith_next    = arith_reg | (|partial[2*WIDTH-1:WIDTH]);
          count_next    = count_reg - CW'(1);
          done_next     = 1'b1;
          state_next    = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) stack_reg[i] <= '0;
      count_reg  <= '0;
      done_reg   <= 1'b0;
      under_reg  <= 1'b0;
      over_reg   <= 1'b0;
      arith_reg  <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      step_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      stack_reg  <= stack_next;
      count_reg  <= count_next;
      done_reg   <= done_next;
      under_reg  <= under_next;
      over_reg   <= over_next;
      arith_reg  <= arith_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      step_reg   <= step_next;
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg == ST_MUL);
  assign done      = done_reg;
  assign top       = stack_reg[0];
  assign second    = stack_reg[1];
  assign count     = count_reg;
  assign err_under = under_reg;
  assign err_over  = over_reg;
  assign err_arith = arith_reg;

endmodule

// File: doc/rpn_stack_alu.md
Name: rpn_stack_alu

Overview:
- Parametrised RPN operand-stack plus ALU core for the calculator datapath.
- Accepts one command per valid/ready handshake: push a literal, or perform an arithmetic or stack operation on the top entries.
- Multiply is a multi-cycle shift-add; all other operations complete in one cycle.
- Provides top-of-stack, second entry, depth and sticky error flags for HEX/LEDR display logic.

Parameters:
- WIDTH, 8: data width of each stack entry and of the operand.
- DEPTH, 4: number of stack entries, minimum 2.
- CW, $clog2(DEPTH+1): width of count (derived, not overridden).

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  core can accept a command.
- op  input  3  command code: 000 PUSH, 001 ADD, 010 SUB, 011 MUL, 100 DUP, 101 SWAP, 110 DROP, 111 CLEAR.
- operand  input  WIDTH  literal for PUSH; ignored otherwise.
- done  output  1  one-cycle pulse when a command retires, including error retirements.
- top  output  WIDTH  stack entry 0; 0 when count==0.
- second  output  WIDTH  stack entry 1; 0 when count<2.
- count  output  CW  number of valid entries, 0..DEPTH.
- busy  output  1  multiply in progress.
- err_under  output  1  sticky underflow flag.
- err_over  output  1  sticky stack-overflow flag.
- err_arith  output  1  sticky arithmetic carry/borrow/overflow flag.

Behaviour:
- Reset (async assert, released synchronously by the clock domain):
  - All stack entries, count, done, busy and error flags go to 0; in_ready goes to 1.
  - Any multiply in progress is aborted; no partial result is written.
- States:
  - IDLE: in_ready=1.
  - MUL: in_ready=0, busy=1.
- Acceptance: a command is accepted on a rising edge where in_valid & in_ready. in_valid while in_ready=0 is ignored with no side effects.
- Single-cycle ops: state updates on the accepting edge; done=1 for the following cycle.
- Stack semantics (T=top, S=second):
  - PUSH: T←operand, others shift down, count+1.
  - ADD: result S+T replaces both entries, count−1. err_arith set on carry out.
  - SUB: result S−T, count−1. err_arith set on borrow (S<T).
  - MUL: result is low WIDTH bits of S×T (unsigned), count−1. err_arith set if the high WIDTH bits are nonzero.
  - DUP: copies T, count+1.
  - SWAP: exchanges T and S.
  - DROP: count−1.
  - CLEAR: count←0, all entries zeroed, all three error flags cleared.
- MUL timing:
  - Accepting edge enters MUL and latches S and T.
  - Exactly WIDTH further edges of shift-add are performed.
  - Result is written on the WIDTH-th edge; done is high the cycle after that edge.
  - in_ready returns to 1 in the same cycle that done is high.
  - Total: acceptance to done = WIDTH+1 cycles.
- Underflow: ADD/SUB/MUL/SWAP with count<2, or DUP/DROP with count==0.
  - Stack unchanged, err_under←1, done pulses.
  - MUL does not enter the MUL state.
- Overflow: PUSH/DUP with count==DEPTH.
  - Stack unchanged, err_over←1, done pulses.
- Error persistence: flags are sticky; only CLEAR or reset clears them. Arithmetic results wrap modulo 2^WIDTH.
- Outputs top, second, count and the flags are registered; they reflect the new state in the cycle done is high.

Test Plan:
1. Assert rst_n=0 mid-stream → count=0, top=0, second=0, flags=0, in_ready=1, busy=0; then release and hold idle 10 cycles → no change.
2. Basic arithmetic (WIDTH=8, DEPTH=4):
   - PUSH 0xA9, PUSH 0x10, ADD → top=0xB9, count=1, err_arith=0.
   - PUSH 0x50, ADD → top=0x09, err_arith=1.
   - CLEAR → count=0, err_arith=0.
3. PUSH 5, PUSH 7, SUB → top=0xFE, err_arith=1. PUSH 3, SWAP → top=0xFE, second=3.
4. Multiply and reset abort:
   - PUSH 12, PUSH 13, MUL → in_ready=0 and busy=1 for 8 cycles; a PUSH held valid meanwhile is ignored.
   - done in the 9th cycle after acceptance → top=0x9C, count=1, err_arith=0.
   - Repeat with rst_n pulsed low 3 cycles into MUL → count=0, in_ready=1, done never pulses.
5. Overflow: PUSH 1..4 → count=4, top=4. PUSH 9 → err_over=1, count=4, top=4, done pulses. DUP → same result.
6. Underflow: from empty, ADD → err_under=1, count=0, done pulses. DROP → unchanged. PUSH 2, MUL → err_under=1, busy stays 0, top=2.
